ar_arbiter: RTL and testbench

AR_ARBITER -- requirements
Module: ar_arbiter

---
 rtl/ar_arbiter_pkg.sv | 28 ++
 rtl/ar_arbiter_rr_select.sv | 29 ++
 rtl/ar_arbiter.sv | 114 +++++++++++
 tb/tb_ar_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ar_arbiter_pkg.sv
// Shared AXI read-address widths, arbiter FSM state encoding and the
// round-robin index helper used by the arbiter and its selector.
package ar_arbiter_pkg;

  localparam int AXI_ADDR_BITS = 32;
  localparam int AXI_LEN_BITS  = 8;
  localparam int AXI_ID_BITS   = 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2
  } ar_state_e;

  typedef struct packed {
    logic [AXI_ADDR_BITS-1:0] addr;
    logic [AXI_LEN_BITS-1:0]  len;
  } ar_req_t;

  // Next master index after idx, wrapping at n.
  function automatic logic [AXI_ID_BITS-1:0] rr_next(
    input logic [AXI_ID_BITS-1:0] idx,
    input int                     n
  );
    return (idx == AXI_ID_BITS'(n - 1)) ? '0 : idx + 1'b1;
  endfunction

endpackage

// File: rtl/ar_arbiter_rr_select.sv
// Combinational round-robin pick: scans from (last+1) with wrap and returns
// the first requesting master.
module rr_select
  import ar_arbiter_pkg::*;
#(
  parameter int NUM_M = 3
) (
  input  logic [NUM_M-1:0]       i_req,
  input  logic [AXI_ID_BITS-1:0] i_last,
  output logic [AXI_ID_BITS-1:0] o_win,
  output logic                   o_vld
);

  logic [AXI_ID_BITS-1:0] w_idx;

  always_comb begin
    o_win = '0;
    o_vld = 1'b0;
    w_idx = i_last;
    for (int k = 0; k < NUM_M; k++) begin
      w_idx = rr_next(w_idx, NUM_M);
      if (!o_vld && i_req[w_idx]) begin
        o_win = w_idx;
        o_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ar_arbiter.sv
// AXI read-address arbiter: three masters share one address decoder port,
// one transaction in flight at a time, round-robin between grants.
module ar_arbiter
  import ar_arbiter_pkg::*;
#(
  parameter int NUM_M = 3
) (
  input  logic                     ACLK,
  input  logic                     ARESET,
  input  logic                     ARVALID_M0,
  input  logic                     ARVALID_M1,
  input  logic                     ARVALID_M2,
  input  logic [AXI_ADDR_BITS-1:0] ARADDR_M0,
  input  logic [AXI_ADDR_BITS-1:0] ARADDR_M1,
  input  logic [AXI_ADDR_BITS-1:0] ARADDR_M2,
  input  logic [AXI_LEN_BITS-1:0]  ARLEN_M0,
  input  logic [AXI_LEN_BITS-1:0]  ARLEN_M1,
  input  logic [AXI_LEN_BITS-1:0]  ARLEN_M2,
  output logic                     ARREADY_M0,
  output logic                     ARREADY_M1,
  output logic                     ARREADY_M2,
  output logic                     ARVALID_S,
  output logic [AXI_ADDR_BITS-1:0] ARADDR_S,
  output logic [AXI_LEN_BITS-1:0]  ARLEN_S,
  output logic [AXI_ID_BITS-1:0]   ARID_S,
  input  logic                     ARREADY_S,
  input  logic                     RVALID_S,
  input  logic                     RREADY_S,
  input  logic                     RLAST_S,
  output logic                     BUSY
);

  ar_state_e              r_state;
  logic [AXI_ID_BITS-1:0] r_gnt;
  logic [AXI_ID_BITS-1:0] r_last;

  logic [NUM_M-1:0]       w_arvalid;
  ar_req_t [NUM_M-1:0]    w_req;
  logic [NUM_M-1:0]       w_arready;
  logic [AXI_ID_BITS-1:0] w_win;
  logic                   w_win_vld;
  logic                   w_in_addr;
  logic                   w_ar_hs;
  logic                   w_r_last_hs;
  ar_req_t                w_sel;

  assign w_arvalid = {ARVALID_M2, ARVALID_M1, ARVALID_M0};
  assign w_req[0]  = {ARADDR_M0, ARLEN_M0};
  assign w_req[1]  = {ARADDR_M1, ARLEN_M1};
  assign w_req[2]  = {ARADDR_M2, ARLEN_M2};

  rr_select #(
    .NUM_M (NUM_M)
  ) u_rr_select (
    .i_req  (w_arvalid),
    .i_last (r_last),
    .o_win  (w_win),
    .o_vld  (w_win_vld)
  );

  assign w_in_addr   = (r_state == S_ADDR);
  assign w_sel       = w_req[r_gnt];
  assign w_ar_hs     = ARVALID_S && ARREADY_S;
  assign w_r_last_hs = RVALID_S && RREADY_S && RLAST_S;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state <= S_IDLE;
      r_gnt   <= '0;
      r_last  <= AXI_ID_BITS'(NUM_M - 1);
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_win_vld) begin
            r_gnt   <= w_win;
            r_last  <= w_win;
            r_state <= S_ADDR;
          end
        end
        // Wait for the decoder; a master withdrawing ARVALID does not abort.
        S_ADDR: begin
          if (w_ar_hs) r_state <= S_DATA;
        end
        S_DATA: begin
          if (w_r_last_hs) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Address path is only open in ADDR; everything else is forced low.
  assign ARVALID_S = w_in_addr && w_arvalid[r_gnt];
  assign ARADDR_S  = w_in_addr ? w_sel.addr : '0;
  assign ARLEN_S   = w_in_addr ? w_sel.len  : '0;
  assign ARID_S    = r_gnt;
  assign BUSY      = (r_state != S_IDLE);

  for (genvar m = 0; m < NUM_M; m++) begin : g_rdy
    assign w_arready[m] = w_in_addr && (r_gnt == AXI_ID_BITS'(m)) && ARREADY_S;
  end

  assign ARREADY_M0 = w_arready[0];
  assign ARREADY_M1 = w_arready[1];
  assign ARREADY_M2 = w_arready[2];

  a_rdy_onehot: assert property (@(posedge ACLK) disable iff (ARESET)
    $onehot0(w_arready));
  a_gnt_range: assert property (@(posedge ACLK) disable iff (ARESET)
    r_gnt < AXI_ID_BITS'(NUM_M));
  a_state_legal: assert property (@(posedge ACLK) disable iff (ARESET)
    r_state inside {S_IDLE, S_ADDR, S_DATA});

endmodule

// File: tb/tb_ar_arbiter.sv
// Directed bench: masters and a decoder/slave model drive the arbiter; a
// monitor checks each address handshake against a queue of expected grants.
module tb_ar_arbiter;

  typedef struct {
    int          id;
    logic [31:0] addr;
    logic [7:0]  len;
    int          cyc;
  } exp_t;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [2:0]  arv;
  logic [31:0] addr_m [3];
  logic [7:0]  len_m  [3];
  wire  [2:0]  arr_m;
  logic        ARVALID_S;
  logic [31:0] ARADDR_S;
  logic [7:0]  ARLEN_S;
  logic [1:0]  ARID_S;
  logic        ARREADY_S, RVALID_S, RREADY_S, RLAST_S;
  logic        BUSY;

  exp_t sbq[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   ar_delay = 0;
  int   last_stall = 0;
  logic slv_busy = 1'b0;
  logic mon_en = 1'b0;

  always #5 ACLK = ~ACLK;

  ar_arbiter #(.NUM_M(3)) dut (
    .ACLK       (ACLK),
    .ARESET     (ARESET),
    .ARVALID_M0 (arv[0]),
    .ARVALID_M1 (arv[1]),
    .ARVALID_M2 (arv[2]),
    .ARADDR_M0  (addr_m[0]),
    .ARADDR_M1  (addr_m[1]),
    .ARADDR_M2  (addr_m[2]),
    .ARLEN_M0   (len_m[0]),
    .ARLEN_M1   (len_m[1]),
    .ARLEN_M2   (len_m[2]),
    .ARREADY_M0 (arr_m[0]),
    .ARREADY_M1 (arr_m[1]),
    .ARREADY_M2 (arr_m[2]),
    .ARVALID_S  (ARVALID_S),
    .ARADDR_S   (ARADDR_S),
    .ARLEN_S    (ARLEN_S),
    .ARID_S     (ARID_S),
    .ARREADY_S  (ARREADY_S),
    .RVALID_S   (RVALID_S),
    .RREADY_S   (RREADY_S),
    .RLAST_S    (RLAST_S),
    .BUSY       (BUSY)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic req(input int m, input logic [31:0] a, input logic [7:0] l);
    addr_m[m] = a;
    len_m[m]  = l;
    arv[m]    = 1'b1;
  endtask

  task automatic push(input int id, input logic [31:0] a, input logic [7:0] l, input int cyc);
    exp_t e;
    e.id = id; e.addr = a; e.len = l; e.cyc = cyc;
    sbq.push_back(e);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      tick();
      if (arv == 3'b000 && !slv_busy && !BUSY && sbq.size() == 0) break;
    end
    n_chk++;
    if (i == budget) begin
      n_err++;
      $display("FAIL %s: timeout after %0d cycles, busy=%0b pending=%0d", tag, budget, BUSY, sbq.size());
    end
  endtask

  task automatic wait_rvalid(input string tag, input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      tick();
      if (RVALID_S) break;
    end
    n_chk++;
    if (i == budget) begin
      n_err++;
      $display("FAIL %s: no read beat within %0d cycles", tag, budget);
    end
  endtask

  // Masters drop ARVALID the cycle after their address is accepted.
  initial begin : release_proc
    logic [2:0] hs;
    forever begin
      @(negedge ACLK);
      hs = arv & arr_m;
      if (hs != 3'b000) begin
        tick();
        arv = arv & ~hs;
      end
    end
  end

  // Decoder/slave: ARREADY after ar_delay cycles, then ARLEN+1 beats.
  initial begin : slave
    int n;
    ARREADY_S = 1'b0; RVALID_S = 1'b0; RREADY_S = 1'b0; RLAST_S = 1'b0;
    forever begin
      tick();
      if (ARVALID_S) begin
        slv_busy = 1'b1;
        n = int'(ARLEN_S);
        repeat (ar_delay) tick();
        ARREADY_S = 1'b1;
        tick();
        ARREADY_S = 1'b0;
        for (int b = 0; b <= n; b++) begin
          RVALID_S = 1'b1;
          RLAST_S  = (b == n);
          if (b == n && last_stall > 0) begin
            RREADY_S = 1'b0;
            repeat (last_stall) tick();
          end
          RREADY_S = 1'b1;
          tick();
        end
        RVALID_S = 1'b0; RREADY_S = 1'b0; RLAST_S = 1'b0;
        slv_busy = 1'b0;
      end
    end
  end

  // Scoreboard monitor and per-cycle protocol checks.
  initial begin : monitor
    int   addr_cyc = 0;
    int   cur_id   = 0;
    logic p_rst = 1'b0, p_data = 1'b0, p_last = 1'b0, p_mid = 1'b0, p_stall = 1'b0, p_want = 1'b0;
    exp_t e;
    wait (mon_en);
    forever begin
      @(negedge ACLK);
      if (!p_rst) begin
        if (p_data && p_last) chk("idle_after_rlast", BUSY, 0);
        if (p_data && (p_mid || p_stall)) chk("stay_in_data", BUSY, 1);
        if (p_want) chk("grant_latency", ARVALID_S, 1);
      end
      if (ARVALID_S) addr_cyc++;
      if (ARVALID_S && ARREADY_S) begin
        if (sbq.size() == 0) begin
          n_chk++; n_err++;
          $display("FAIL unexpected_grant: id %0d granted, expected none", ARID_S);
        end else begin
          e = sbq.pop_front();
          chk("arid", ARID_S, e.id);
          chk("araddr", ARADDR_S, e.addr);
          chk("arlen", ARLEN_S, e.len);
          chk("addr_cycles", addr_cyc, e.cyc);
          chk("arready_m_hs", arr_m, 64'(1 << e.id));
          cur_id = e.id;
        end
        addr_cyc = 0;
      end else begin
        chk("arready_m_quiet", arr_m, 0);
      end
      if (!ARVALID_S) begin
        chk("araddr_zero", ARADDR_S, 0);
        chk("arlen_zero", ARLEN_S, 0);
        chk("arid_hold", ARID_S, cur_id);
      end
      if (ARESET) begin
        cur_id = 0;
        addr_cyc = 0;
      end
      p_rst   = ARESET;
      p_data  = BUSY && !ARVALID_S;
      p_last  = RVALID_S && RREADY_S && RLAST_S;
      p_mid   = RVALID_S && RREADY_S && !RLAST_S;
      p_stall = RVALID_S && !RREADY_S;
      p_want  = !BUSY && (arv != 3'b000) && !ARESET;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    arv = 3'b000;
    for (int i = 0; i < 3; i++) begin addr_m[i] = '0; len_m[i] = '0; end
    ARESET = 1'b1;

    // Reset state
    repeat (2) @(posedge ACLK);
    @(negedge ACLK);
    chk("rst_busy", BUSY, 0);
    chk("rst_arvalid", ARVALID_S, 0);
    chk("rst_arid", ARID_S, 0);
    chk("rst_arready_m", arr_m, 0);
    tick();
    ARESET = 1'b0;
    @(negedge ACLK);
    chk("post_rst_busy", BUSY, 0);
    chk("post_rst_araddr", ARADDR_S, 0);
    mon_en = 1'b1;

    // All three request together: M0, M1, M2 in order
    tick();
    req(0, 32'h0000_1000, 8'd0);
    req(1, 32'h0000_1100, 8'd1);
    req(2, 32'h0000_1200, 8'd2);
    push(0, 32'h0000_1000, 8'd0, 1);
    push(1, 32'h0000_1100, 8'd1, 1);
    push(2, 32'h0000_1200, 8'd2, 1);
    wait_done("rr_all_three", 200);

    // M1, 4-beat burst, decoder ready delayed 2 cycles
    ar_delay = 2;
    req(1, 32'h0001_0040, 8'd3);
    push(1, 32'h0001_0040, 8'd3, 3);
    wait_done("m1_delayed_ready", 200);
    ar_delay = 0;

    // M2 arrives while M0 is in DATA: held off until M0's RLAST
    req(0, 32'h0000_2000, 8'd3);
    push(0, 32'h0000_2000, 8'd3, 1);
    wait_rvalid("m0_data", 50);
    req(2, 32'h0000_3000, 8'd0);
    push(2, 32'h0000_3000, 8'd0, 1);
    @(negedge ACLK);
    chk("m2_held_in_data", arr_m[2], 0);
    chk("m2_held_busy", BUSY, 1);
    wait_done("m2_after_m0", 200);

    // RLAST without RREADY must not end the transaction
    last_stall = 2;
    req(0, 32'h0000_4000, 8'd1);
    push(0, 32'h0000_4000, 8'd1, 1);
    wait_done("rlast_stall", 200);
    last_stall = 0;

    // Reset mid-DATA of an M1 burst restores M0-first priority
    req(1, 32'h0000_5000, 8'd7);
    push(1, 32'h0000_5000, 8'd7, 1);
    wait_rvalid("m1_long_data", 50);
    tick();
    ARESET = 1'b1;
    tick();
    ARESET = 1'b0;
    @(negedge ACLK);
    chk("abort_busy", BUSY, 0);
    chk("abort_arid", ARID_S, 0);
    chk("abort_arvalid", ARVALID_S, 0);
    for (int i = 0; i < 50 && slv_busy; i++) tick();
    tick();
    @(negedge ACLK);
    chk("rlast_in_idle_ignored", BUSY, 0);
    tick();
    req(1, 32'h0000_6000, 8'd0);
    req(2, 32'h0000_7000, 8'd0);
    push(1, 32'h0000_6000, 8'd0, 1);
    push(2, 32'h0000_7000, 8'd0, 1);
    wait_done("post_reset_order", 200);

    // Lone M2 repeatedly
    for (int i = 0; i < 3; i++) begin
      req(2, 32'h0000_8000 + 32'(i * 16), 8'(i));
      push(2, 32'h0000_8000 + 32'(i * 16), 8'(i), 1);
      wait_done("m2_lone", 200);
    end

    repeat (3) tick();
    chk("scoreboard_empty", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
